// File: rtl/async_pkg.sv
// Shared definitions for the self-timed/synchronous boundary blocks:
// grant-sync FSM state encoding, FIFO pointer width rule and the
// one-hot to binary conversion used when capturing arbiter grants.
package async_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACK_HI = 1'b1
    } grant_sync_state_t;

    // Widest grant vector onehot2bin accepts; narrower vectors are zero-extended.
    localparam int unsigned SEL_MAX_W = 1024;

    // Pointers carry one extra bit so that full and empty are distinguishable
    // when the address bits are equal.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    // Index of the lowest set bit among the low 'width' bits of vec; 0 if none.
    function automatic logic [31:0] onehot2bin(input logic [SEL_MAX_W-1:0] vec,
                                               input int unsigned         width);
        logic [31:0] idx;
        logic        found;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < SEL_MAX_W; i++) begin
            if (i < width && !found && vec[i]) begin
                idx   = i;
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-stage synchroniser for signals arriving asynchronously to clk.
// Reset clears both stages so downstream logic sees 0 until a real
// transition has propagated through.
module sync_2ff #(
    parameter int unsigned width = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [width-1:0] d,
    output logic [width-1:0] q
);

    logic [width-1:0] meta;

    // Shift the asynchronous input through two flops.
    // NOTE: non-blocking assignments make both stages sample the pre-edge
    // values; blocking here would collapse the chain into a single flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/arbiter_grant_sync.sv
// Clocked consumer of the cascade arbiter's four-phase req_out/ack_out
// handshake. Each captured grant is converted from one-hot to a binary
// index, buffered in a small FIFO and presented on a valid/ready stream.
// Optional build macro SEL_CHECK_EN adds a sticky non-one-hot detector on
// sel_err; without it sel_err is tied to 0.
module arbiter_grant_sync
    import async_pkg::*;
#(
    parameter int unsigned input_size = 32,
    parameter int unsigned fifo_depth = 4,
    parameter int unsigned idx_w      = $clog2(input_size)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_out,
    output logic                  ack_out,
    input  logic [input_size-1:0] sel,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [idx_w-1:0]      out_index,
    output logic                  sel_err
);

    localparam int unsigned addr_w = $clog2(fifo_depth);
    localparam int unsigned ptr_w  = ptr_width(fifo_depth);

    logic              req_s;
    grant_sync_state_t state, state_n;
    logic              ack_n;
    logic              push;
    logic              pop;
    logic              full;
    logic [ptr_w-1:0]  wr_ptr, rd_ptr, rd_ptr_n;
    logic [ptr_w-1:0]  count;
    logic [idx_w-1:0]  cap_idx;
    logic [idx_w-1:0]  mem [fifo_depth];

    sync_2ff #(.width(1)) u_req_sync (
        .clk   (clk),
        .rst_n (rst),
        .d     (req_out),
        .q     (req_s)
    );

    // sel is bundled with req_out and already stable when req_s rises.
    assign cap_idx  = idx_w'(onehot2bin(SEL_MAX_W'(sel), input_size));

    // Occupancy as seen at the start of the cycle; a same-cycle pop does
    // not free a slot for a push.
    assign count    = wr_ptr - rd_ptr;
    assign full     = (count == ptr_w'(fifo_depth));
    assign pop      = out_valid && out_ready;
    assign rd_ptr_n = rd_ptr + ptr_w'(pop);

    // Handshake FSM: capture on request, return-to-zero on request release.
    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_n = state;
        ack_n   = ack_out;
        push    = 1'b0;
        case (state)
            IDLE: begin
                if (req_s && !full) begin
                    push    = 1'b1;
                    ack_n   = 1'b1;
                    state_n = ACK_HI;
                end
            end
            ACK_HI: begin
                if (!req_s) begin
                    ack_n   = 1'b0;
                    state_n = IDLE;
                end
            end
            default: begin
                ack_n   = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

    // FSM state and registered acknowledge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            ack_out <= 1'b0;
        end else begin
            state   <= state_n;
            ack_out <= ack_n;
        end
    end

    // FIFO pointers and the registered head; a freshly pushed entry becomes
    // visible one cycle after its write, while a pop exposes the next head
    // on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            out_valid <= 1'b0;
            out_index <= '0;
        end else begin
            wr_ptr    <= wr_ptr + ptr_w'(push);
            rd_ptr    <= rd_ptr_n;
            out_valid <= (wr_ptr != rd_ptr_n);
            out_index <= mem[rd_ptr_n[addr_w-1:0]];
        end
    end

    // FIFO storage write port.
    // NOTE: the array is deliberately not reset; entries are only ever read
    // behind the pointers, which are reset, so stale contents are never seen.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[addr_w-1:0]] <= cap_idx;
        end
    end

`ifdef SEL_CHECK_EN
    // Sticky flag for a grant vector that is not exactly one-hot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_err <= 1'b0;
        end else if (push && !$onehot(sel)) begin
            sel_err <= 1'b1;
        end
    end
`else
    assign sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_arbiter_grant_sync.sv
// Self-checking bench for arbiter_grant_sync: table-driven grant vectors
// with a scoreboard queue of expected indices, plus hand-written sequences
// for back-pressure, full-with-pop, reset mid-handshake and sel checking.
module tb_arbiter_grant_sync;

    localparam int unsigned INPUT_SIZE = 32;
    localparam int unsigned IDX_W      = 5;
`ifdef SEL_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic                  clk;
    logic                  rst;
    logic                  req_out;
    logic                  ack_out;
    logic [INPUT_SIZE-1:0] sel;
    logic                  out_valid;
    logic                  out_ready;
    logic [IDX_W-1:0]      out_index;
    logic                  sel_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [IDX_W-1:0] sb_q[$];

    typedef struct {
        logic [INPUT_SIZE-1:0] sel;
        logic [IDX_W-1:0]      exp_index;
    } vec_t;

    vec_t vecs[10];

    arbiter_grant_sync #(
        .input_size (INPUT_SIZE),
        .fifo_depth (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_out   (req_out),
        .ack_out   (ack_out),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .sel_err   (sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every accepted head is compared against the oldest expected index.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected_pop: got index %0d, expected no entry", out_index);
            end else begin
                logic [IDX_W-1:0] exp;
                exp = sb_q.pop_front();
                check("sb_index", 32'(out_index), 32'(exp));
            end
        end
    end

    // Wait (bounded) for ack_out to reach val; n is the number of edges taken.
    task automatic wait_ack(input logic val, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (ack_out !== val && n < 20);
        check("ack_reached", 32'(ack_out), 32'(val));
    endtask

    // One complete four-phase handshake with latency checks.
    task automatic grant(input logic [INPUT_SIZE-1:0] s, input logic [IDX_W-1:0] exp_idx);
        int n;
        sel = s;
        sb_q.push_back(exp_idx);
        @(posedge clk);
        #1;
        req_out = 1'b1;
        wait_ack(1'b1, n);
        check("ack_rise_latency", 32'(n), 32'd3);
        req_out = 1'b0;
        wait_ack(1'b0, n);
        check("ack_fall_latency", 32'(n), 32'd3);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int n;

        vecs[0] = '{32'h0000_0001, 5'd0};
        vecs[1] = '{32'h8000_0000, 5'd31};
        vecs[2] = '{32'h0000_0020, 5'd5};
        vecs[3] = '{32'h0002_0000, 5'd17};
        vecs[4] = '{32'h0000_0002, 5'd1};
        vecs[5] = '{32'h4000_0000, 5'd30};
        vecs[6] = '{32'h0000_1000, 5'd12};
        vecs[7] = '{32'h0080_0000, 5'd23};
        vecs[8] = '{32'h0000_0004, 5'd2};
        vecs[9] = '{32'h0100_0000, 5'd24};

        rst       = 1'b0;
        req_out   = 1'b0;
        sel       = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack_out", 32'(ack_out), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_index", 32'(out_index), 32'd0);
        check("rst_sel_err", 32'(sel_err), 32'd0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single grant on channel 8, with head visibility one cycle after ack.
        out_ready = 1'b1;
        sel = 32'h0000_0100;
        sb_q.push_back(5'd8);
        req_out = 1'b1;
        wait_ack(1'b1, n);
        check("single_rise_latency", 32'(n), 32'd3);
        check("single_valid_lag", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        check("single_valid", 32'(out_valid), 32'd1);
        check("single_index", 32'(out_index), 32'd8);
        req_out = 1'b0;
        wait_ack(1'b0, n);
        check("single_fall_latency", 32'(n), 32'd3);
        repeat (3) @(posedge clk);
        #1;
        check("single_drained", 32'(sb_q.size()), 32'd0);

        // Ten grants through the FIFO with the consumer always ready (pointer wrap).
        for (int i = 0; i < 10; i++) begin
            grant(vecs[i].sel, vecs[i].exp_index);
        end
        repeat (4) @(posedge clk);
        #1;
        check("wrap_drained", 32'(sb_q.size()), 32'd0);
        check("wrap_valid_low", 32'(out_valid), 32'd0);

        // Back-pressure: four grants fill the FIFO, the fifth is held off.
        out_ready = 1'b0;
        for (int ch = 1; ch <= 4; ch++) begin
            grant(INPUT_SIZE'(1) << ch, IDX_W'(ch));
        end
        sel = 32'h0000_0020;
        sb_q.push_back(5'd5);
        req_out = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("bp_ack_held", 32'(ack_out), 32'd0);
        check("bp_head_valid", 32'(out_valid), 32'd1);
        check("bp_head_index", 32'(out_index), 32'd1);

        // Full with a pop in the same cycle: no push that edge, push on the next.
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("full_pop_no_push", 32'(ack_out), 32'd0);
        check("pop_next_head", 32'(out_index), 32'd2);
        @(posedge clk);
        #1;
        check("push_after_pop", 32'(ack_out), 32'd1);
        req_out = 1'b0;
        wait_ack(1'b0, n);
        out_ready = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("bp_drained", 32'(sb_q.size()), 32'd0);

        // Reset asserted while in ACK_HI with an entry buffered.
        out_ready = 1'b0;
        sel = 32'h0000_0008;
        req_out = 1'b1;
        wait_ack(1'b1, n);
        @(posedge clk);
        #1;
        check("prerst_valid", 32'(out_valid), 32'd1);
        rst = 1'b0;
        #1;
        check("midrst_ack", 32'(ack_out), 32'd0);
        check("midrst_valid", 32'(out_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        sb_q.push_back(5'd3);
        wait_ack(1'b1, n);
        check("postrst_rise_latency", 32'(n), 32'd3);
        out_ready = 1'b1;
        req_out = 1'b0;
        wait_ack(1'b0, n);
        repeat (6) @(posedge clk);
        #1;
        check("postrst_one_capture", 32'(sb_q.size()), 32'd0);
        check("postrst_valid_low", 32'(out_valid), 32'd0);

        // Non-one-hot grant vector, then a clean one to confirm stickiness.
        check("sel_err_before", 32'(sel_err), 32'd0);
        grant(32'h0000_0006, 5'd1);
        @(posedge clk);
        #1;
        check("sel_err_set", 32'(sel_err), 32'(EXP_ERR));
        grant(32'h0000_0010, 5'd4);
        repeat (4) @(posedge clk);
        #1;
        check("sel_err_sticky", 32'(sel_err), 32'(EXP_ERR));
        check("final_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
